triangle_raster_scan: RTL and testbench
=======================================

Name: triangle_raster_scan

Overview:
Sequential producer for the point-in-triangle datapath. It latches three vertices, computes the bounding box and the doubled triangle area, then scans every integer point in the box in row-major order. Each point is tested with the three-sub-area equality test. Covered points are emitted on a valid/ready stream to downstream pixel logic. This block supplies the (px, py) points that the triangle test consumes.

Parameters:
COORD_W, 9, coordinate width in bits, unsigned; scan range 0..2^COORD_W-1
CNT_W, 2*COORD_W+1, width of the covered-pixel counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a job; sampled only in IDLE
ax, ay, bx, by, cx, cy  in  COORD_W each  vertex coordinates, latched when start is accepted
pix_ready  in  1  downstream accepts the current pixel
pix_valid  out  1  px/py hold a covered pixel
px, py  out  COORD_W each  current scan cursor
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse at job end
pix_count  out  CNT_W  covered pixels emitted in the current or last job

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port is clk, reset port is rst_n.
- Reset values: all outputs 0, state IDLE, vertex and bbox registers 0.
- The FSM has four states: IDLE, SETUP, SCAN, FIN.
- IDLE: when start=1 on a clock edge, latch the six vertex inputs, clear pix_count, set busy=1, go to SETUP. Start pulses outside IDLE are ignored.
- SETUP (exactly 1 cycle):
  - xmin/xmax = min/max(ax, bx, cx); ymin/ymax likewise.
  - AT = |ax(by-cy) + bx(cy-ay) + cx(ay-by)|, signed intermediate width 2*COORD_W+3, result unsigned.
  - Cursor px=xmin, py=ymin.
  - If AT==0 (degenerate: collinear or coincident vertices), go to FIN and emit no pixels. Otherwise go to SCAN.
- SCAN:
  - inside = (|A(a,b,p)| + |A(a,p,c)| + |A(p,b,c)| == AT), using the same width rules as AT. Edges and vertices count as inside; the result is independent of winding order.
  - pix_valid = inside (combinational from registered cursor and vertices); it is 0 in every other state.
  - Cursor advances when !inside, or when inside && pix_ready. pix_count increments on each inside && pix_ready.
  - While pix_valid && !pix_ready: px, py, pix_valid are held stable (no drop, no duplicate).
  - Advance order: px++. When px==xmax, px=xmin and py++.
  - Advancing past (xmax, ymax) goes to FIN. No wrap-around past 2^COORD_W-1 can occur.
- Throughput: one candidate point per cycle with pix_ready held high.
- FIN (1 cycle): done=1, busy=0 on exit, go to IDLE. pix_count holds its value until the next accepted start.
- A start asserted in the same cycle as done is ignored; it is accepted the next cycle in IDLE.
- Reset asserted mid-job aborts immediately: IDLE, all outputs 0, no done pulse.

Test Plan:
- Vertices (0,0),(4,0),(0,4), pix_ready=1 -> 15 pixels satisfying x+y<=4. First (0,0), last (0,4). done one cycle after the last candidate, pix_count=15, total busy cycles = 1 SETUP + 25 SCAN + 1 FIN.
- Same triangle with pix_ready toggled pseudo-randomly -> identical 15-pixel sequence. px/py stable while stalled, pix_count=15.
- Reversed winding (0,0),(0,4),(4,0) -> same 15 pixels. Degenerate (0,0),(2,2),(5,5) -> SETUP then FIN, pix_valid never high, pix_count=0.
- Boundary vertices (511,511),(510,511),(511,510) -> exactly 3 pixels: (511,510), (510,511), (511,511). No overflow or wrap.
- Single point (7,7)x3 -> AT=0, done with pix_count=0. start pulsed during SCAN -> ignored, job unchanged.
- rst_n low during SCAN of the first triangle -> outputs 0 asynchronously, no done. A new start after release completes normally.

Source files
------------

// File: rtl/triangle_raster_scan.sv
// Scans the bounding box of a latched triangle in row-major order and streams
// every covered integer point (edges and vertices included) on a valid/ready port.
module triangle_raster_scan #(
  parameter int COORD_W = 9,
  parameter int CNT_W   = 2*COORD_W+1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COORD_W-1:0] ax,
  input  logic [COORD_W-1:0] ay,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  input  logic               pix_ready,
  output logic               pix_valid,
  output logic [COORD_W-1:0] px,
  output logic [COORD_W-1:0] py,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   pix_count
);

  localparam int AW = 2*COORD_W+3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SCAN  = 2'd2,
    FIN   = 2'd3
  } state_t;

  // Doubled unsigned area of (x1,y1),(x2,y2),(x3,y3); AW bits hold the signed sum without overflow.
  function automatic logic [AW-1:0] tri_area(
    input logic [COORD_W-1:0] x1, input logic [COORD_W-1:0] y1,
    input logic [COORD_W-1:0] x2, input logic [COORD_W-1:0] y2,
    input logic [COORD_W-1:0] x3, input logic [COORD_W-1:0] y3
  );
    logic signed [AW-1:0] sx1, sy1, sx2, sy2, sx3, sy3, sum;
    sx1 = AW'(x1); sy1 = AW'(y1);
    sx2 = AW'(x2); sy2 = AW'(y2);
    sx3 = AW'(x3); sy3 = AW'(y3);
    sum = sx1 * (sy2 - sy3) + sx2 * (sy3 - sy1) + sx3 * (sy1 - sy2);
    if (sum[AW-1]) begin
      tri_area = $unsigned(-sum);
    end else begin
      tri_area = $unsigned(sum);
    end
  endfunction

  function automatic logic [COORD_W-1:0] min3(
    input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b, input logic [COORD_W-1:0] c
  );
    logic [COORD_W-1:0] m;
    m = (a < b) ? a : b;
    min3 = (m < c) ? m : c;
  endfunction

  function automatic logic [COORD_W-1:0] max3(
    input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b, input logic [COORD_W-1:0] c
  );
    logic [COORD_W-1:0] m;
    m = (a > b) ? a : b;
    max3 = (m > c) ? m : c;
  endfunction

  state_t             state_r, state_next_s;
  logic [COORD_W-1:0] ax_r, ay_r, bx_r, by_r, cx_r, cy_r;
  logic [COORD_W-1:0] xmin_r, xmax_r, ymin_r, ymax_r;
  logic [COORD_W-1:0] px_r, py_r;
  logic [AW-1:0]      at_r, at_setup_s, a0_s, a1_s, a2_s;
  logic [AW+1:0]      sub_sum_s;
  logic               inside_s, adv_s, last_s;
  logic               busy_r, done_r;
  logic [CNT_W-1:0]   cnt_r;

  // Coverage test of the registered cursor and scan-advance decision
  always_comb begin
    at_setup_s = tri_area(ax_r, ay_r, bx_r, by_r, cx_r, cy_r);
    a0_s       = tri_area(ax_r, ay_r, bx_r, by_r, px_r, py_r);
    a1_s       = tri_area(ax_r, ay_r, px_r, py_r, cx_r, cy_r);
    a2_s       = tri_area(px_r, py_r, bx_r, by_r, cx_r, cy_r);
    sub_sum_s  = {2'b00, a0_s} + {2'b00, a1_s} + {2'b00, a2_s};
    inside_s   = (state_r == SCAN) && (sub_sum_s == {2'b00, at_r});
    adv_s      = (state_r == SCAN) && (!inside_s || pix_ready);
    last_s     = (px_r == xmax_r) && (py_r == ymax_r);
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = SETUP;
        end else begin
          state_next_s = IDLE;
        end
      end
      SETUP: begin
        if (at_setup_s == {AW{1'b0}}) begin
          state_next_s = FIN;
        end else begin
          state_next_s = SCAN;
        end
      end
      SCAN: begin
        if (adv_s && last_s) begin
          state_next_s = FIN;
        end else begin
          state_next_s = SCAN;
        end
      end
      FIN:     state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register with registered busy/done derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != IDLE);
      done_r  <= (state_next_s == FIN);
    end
  end

  // Vertex latch, bounding box setup, cursor walk and pixel counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ax_r <= '0; ay_r <= '0; bx_r <= '0; by_r <= '0; cx_r <= '0; cy_r <= '0;
      xmin_r <= '0; xmax_r <= '0; ymin_r <= '0; ymax_r <= '0;
      px_r <= '0; py_r <= '0; at_r <= '0; cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            ax_r <= ax; ay_r <= ay; bx_r <= bx; by_r <= by; cx_r <= cx; cy_r <= cy;
            cnt_r <= '0;
          end
        end
        SETUP: begin
          xmin_r <= min3(ax_r, bx_r, cx_r);
          xmax_r <= max3(ax_r, bx_r, cx_r);
          ymin_r <= min3(ay_r, by_r, cy_r);
          ymax_r <= max3(ay_r, by_r, cy_r);
          px_r   <= min3(ax_r, bx_r, cx_r);
          py_r   <= min3(ay_r, by_r, cy_r);
          at_r   <= at_setup_s;
        end
        SCAN: begin
          if (inside_s && pix_ready) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
          // px is never incremented at xmax, so the scan cannot wrap at the range top
          if (adv_s) begin
            if (px_r == xmax_r) begin
              px_r <= xmin_r;
              if (py_r != ymax_r) begin
                py_r <= py_r + COORD_W'(1);
              end
            end else begin
              px_r <= px_r + COORD_W'(1);
            end
          end
        end
        FIN: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign pix_valid = inside_s;
  assign px        = px_r;
  assign py        = py_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pix_count = cnt_r;

endmodule

// File: tb/tb_triangle_raster_scan.sv
// Scoreboard bench for triangle_raster_scan: an edge-sign reference model queues
// the expected pixel stream, which is popped on every accepted handshake.
module tb_triangle_raster_scan;

  localparam int W  = 9;
  localparam int CW = 2*W+1;

  logic          clk = 1'b0;
  logic          rst_n, start, pix_ready;
  logic [W-1:0]  ax, ay, bx, by, cx, cy;
  logic          pix_valid, busy, done;
  logic [W-1:0]  px, py;
  logic [CW-1:0] pix_count;

  triangle_raster_scan #(.COORD_W(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
    .pix_ready(pix_ready), .pix_valid(pix_valid), .px(px), .py(py),
    .busy(busy), .done(done), .pix_count(pix_count)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; } pt_t;
  pt_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check_eq(input string tag, input longint obs, input longint expv);
    n_checks++;
    if (obs == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
  endtask

  function automatic longint edge_fn(int x1, int y1, int x2, int y2, int x3, int y3);
    return longint'((x2 - x1) * (y3 - y1)) - longint'((y2 - y1) * (x3 - x1));
  endfunction

  // Reference: a point is covered when all three edge functions share a sign (zero allowed)
  task automatic build_expected(input int vax, vay, vbx, vby, vcx, vcy);
    longint e0, e1, e2;
    int xlo, xhi, ylo, yhi;
    pt_t p;
    exp_q.delete();
    if (edge_fn(vax, vay, vbx, vby, vcx, vcy) != 0) begin
      xlo = vax; if (vbx < xlo) xlo = vbx; if (vcx < xlo) xlo = vcx;
      xhi = vax; if (vbx > xhi) xhi = vbx; if (vcx > xhi) xhi = vcx;
      ylo = vay; if (vby < ylo) ylo = vby; if (vcy < ylo) ylo = vcy;
      yhi = vay; if (vby > yhi) yhi = vby; if (vcy > yhi) yhi = vcy;
      for (int y = ylo; y <= yhi; y++) begin
        for (int x = xlo; x <= xhi; x++) begin
          e0 = edge_fn(vax, vay, vbx, vby, x, y);
          e1 = edge_fn(vbx, vby, vcx, vcy, x, y);
          e2 = edge_fn(vcx, vcy, vax, vay, x, y);
          if ((e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0)) begin
            p.x = x; p.y = y;
            exp_q.push_back(p);
          end
        end
      end
    end
  endtask

  task automatic run_job(input int vax, vay, vbx, vby, vcx, vcy,
                         input bit rnd, input int exp_busy, input bit poke, input bit chain);
    int   n_exp, busy_cycles;
    bit   held, got_done;
    logic [W-1:0] hx, hy;
    pt_t  p;
    build_expected(vax, vay, vbx, vby, vcx, vcy);
    n_exp = exp_q.size();
    @(negedge clk);
    ax = W'(vax); ay = W'(vay); bx = W'(vbx); by = W'(vby); cx = W'(vcx); cy = W'(vcy);
    start = 1'b1; pix_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cycles = 0; held = 1'b0; got_done = 1'b0; hx = '0; hy = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (poke && cyc == 10) begin
        start = 1'b1; ax = W'(300); by = W'(200);
      end else begin
        start = 1'b0;
      end
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (busy) busy_cycles++;
      if (held) begin
        check_eq("stall_valid", pix_valid, 1);
        check_eq("stall_px", px, hx);
        check_eq("stall_py", py, hy);
      end
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("pix_overrun", pix_valid, 0);
        end else begin
          p = exp_q.pop_front();
          check_eq("pix_x", px, p.x);
          check_eq("pix_y", py, p.y);
        end
      end
      held = pix_valid && !pix_ready;
      hx = px; hy = py;
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    check_eq("done_seen", got_done, 1);
    check_eq("valid_at_done", pix_valid, 0);
    check_eq("count_at_done", pix_count, n_exp);
    check_eq("queue_left", exp_q.size(), 0);
    if (exp_busy > 0) check_eq("busy_cycles", busy_cycles, exp_busy);
    if (chain) begin
      start = 1'b1;
      ax = W'(7); ay = W'(7); bx = W'(7); by = W'(7); cx = W'(7); cy = W'(7);
    end
    pix_ready = 1'b1;
    @(negedge clk); #1;
    check_eq("done_pulse", done, 0);
    check_eq("busy_after", busy, 0);
    check_eq("count_hold", pix_count, n_exp);
    if (chain) begin
      @(negedge clk); #1;
      check_eq("chain_accept", busy, 1);
      start = 1'b0;
      @(negedge clk); #1;
      check_eq("chain_done", done, 1);
      check_eq("chain_count", pix_count, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pix_ready = 1'b1;
    ax = '0; ay = '0; bx = '0; by = '0; cx = '0; cy = '0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_valid", pix_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_px", px, 0);
    check_eq("rst_py", py, 0);
    check_eq("rst_count", pix_count, 0);
    rst_n = 1'b1;

    run_job(0, 0, 4, 0, 0, 4, 1'b0, 27, 1'b0, 1'b0);
    run_job(0, 0, 4, 0, 0, 4, 1'b1, -1, 1'b0, 1'b0);
    run_job(0, 0, 0, 4, 4, 0, 1'b0, 27, 1'b1, 1'b0);
    run_job(0, 0, 2, 2, 5, 5, 1'b0, 2, 1'b0, 1'b1);
    run_job(511, 511, 510, 511, 511, 510, 1'b0, 6, 1'b0, 1'b0);
    run_job(511, 511, 510, 511, 511, 510, 1'b1, -1, 1'b0, 1'b0);
    run_job(7, 7, 7, 7, 7, 7, 1'b0, 2, 1'b0, 1'b0);

    // Abort a job mid-scan with an asynchronous reset
    @(negedge clk);
    ax = W'(0); ay = W'(0); bx = W'(4); by = W'(0); cx = W'(0); cy = W'(4);
    start = 1'b1; pix_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_valid", pix_valid, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_px", px, 0);
    check_eq("abort_py", py, 0);
    check_eq("abort_count", pix_count, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check_eq("abort_no_done", done, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_job(0, 0, 4, 0, 0, 4, 1'b1, -1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
